// File: rtl/booth_seq_mul_if.sv
// Handshake and operand/result bundle for the iterative Booth multiplier.
interface booth_seq_mul_if #(
  parameter int BITWIDTH = 16
);
  logic                    start;
  logic                    is_signed;
  logic [BITWIDTH-1:0]     multiplicand;
  logic [BITWIDTH-1:0]     multiplier;
  logic                    busy;
  logic                    done;
  logic [2*BITWIDTH-1:0]   product;

  // Requester side: issues operands and start, observes status/result.
  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product
  );

  // Multiplier side.
  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock through a
// single recode/add stage. Multiplicand is pre-shifted by two bits per digit
// and the multiplier window slides right by two, so no barrel shifter needed.
module booth_seq_mul #(
  parameter int BITWIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_seq_mul_if.slave   bus
);

  localparam int PW = 2 * BITWIDTH;        // accumulator / product width
  localparam int MW = BITWIDTH + 3;        // {ext, ext, B, bit -1}
  localparam int CW = $clog2(BITWIDTH / 2 + 2);

  // Index of the final digit: signed needs BITWIDTH/2 digits, unsigned one
  // more so the zero-extended top digit {0,0,B[MSB]} is applied.
  localparam logic [CW-1:0] LAST_S = CW'(BITWIDTH / 2 - 1);
  localparam logic [CW-1:0] LAST_U = CW'(BITWIDTH / 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            sgn_q, sgn_d;
  logic [PW-1:0]   mcand_q, mcand_d;   // A, extended, shifted left 2 per digit
  logic [MW-1:0]   mplr_q, mplr_d;     // B window, low 3 bits = current digit
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            done_q, done_d;

  logic [PW-1:0]   pp_mag;
  logic            pp_neg;
  logic [PW-1:0]   sum;
  logic            ext_a, ext_b;
  logic [CW-1:0]   last_cnt;

  // Booth recode of the current digit and the single add/subtract stage.
  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    case (mplr_q[2:0])
      3'b001, 3'b010: pp_mag = mcand_q;
      3'b011:         pp_mag = mcand_q << 1;
      3'b100: begin
        pp_mag = mcand_q << 1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = mcand_q;
        pp_neg = 1'b1;
      end
      default: begin
        pp_mag = '0;
        pp_neg = 1'b0;
      end
    endcase
    // Subtraction as invert plus carry-in, wrapping modulo 2^PW.
    sum = acc_q + (pp_neg ? ~pp_mag : pp_mag) + {{(PW-1){1'b0}}, pp_neg};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    sgn_d    = sgn_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    ext_a    = bus.is_signed & bus.multiplicand[BITWIDTH-1];
    ext_b    = bus.is_signed & bus.multiplier[BITWIDTH-1];
    last_cnt = sgn_q ? LAST_S : LAST_U;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          sgn_d   = bus.is_signed;
          mcand_d = {{BITWIDTH{ext_a}}, bus.multiplicand};
          mplr_d  = {ext_b, ext_b, bus.multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        acc_d   = sum;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == last_cnt) begin
          state_d = S_DONE;
          prod_d  = sum;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.product = prod_q;

endmodule
